icache_fill: RTL

- Direct-mapped instruction cache feeding the IFM1 fetch stage.
- Looks up PcReq_SY0 and returns InstrFill_SY0 in the same cycle on a hit.
- On a miss, raises ICacheStall, which is ORed into AnyStall by the pipeline. It then refills the whole line from the memory port, word by word.
- Fetch holds its PC while stalled. After the refill completes, the same request hits.

---
 rtl/icache_fill.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/icache_fill.sv
// icache_fill: direct-mapped, read-only instruction cache for the IFM1 fetch stage.
// A hit returns the instruction in the same cycle. A miss stalls fetch and refills
// the whole line in word order over a simple req/ack memory port.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   PcReq_SY0       fetch address (bits [1:0] ignored)
//   InvalidateAll   clear all valid bits (the line being filled is kept)
//   InstrFill_SY0   instruction word, meaningful when ICacheStall=0
//   ICacheStall     miss or refill in progress
//   MemReq/MemAddr  refill word request, held until MemAck
//   MemAck/MemRdata memory accepted the request, read data valid
module icache_fill #(
  parameter int unsigned LINES      = 64,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PcReq_SY0,
  input  logic        InvalidateAll,
  output logic [31:0] InstrFill_SY0,
  output logic        ICacheStall,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemAck,
  input  logic [31:0] MemRdata
);

  localparam int unsigned OFFB  = $clog2(LINE_WORDS);
  localparam int unsigned IDXB  = $clog2(LINES);
  localparam int unsigned TAGB  = 30 - OFFB - IDXB;
  localparam int unsigned LINEB = TAGB + IDXB;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REFILL = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      data_q [LINES*LINE_WORDS];
  logic [TAGB-1:0]  tag_q  [LINES];
  logic [LINES-1:0] valid_q, valid_d;

  logic [LINEB-1:0] miss_line_q, miss_line_d;
  logic [OFFB-1:0]  word_cnt_q, word_cnt_d;

  logic [OFFB-1:0]  req_off;
  logic [IDXB-1:0]  req_idx;
  logic [TAGB-1:0]  req_tag;
  logic [IDXB-1:0]  miss_idx;
  logic [TAGB-1:0]  miss_tag;
  logic             hit;
  logic             fill_ack;
  logic             fill_last;
  logic [LINES-1:0] fill_mask;
  logic             unused_pc_lsb;

  // Address decode for the lookup and for the line being refilled
  assign req_off  = PcReq_SY0[OFFB+1:2];
  assign req_idx  = PcReq_SY0[OFFB+IDXB+1:OFFB+2];
  assign req_tag  = PcReq_SY0[31:OFFB+IDXB+2];
  assign miss_idx = miss_line_q[IDXB-1:0];
  assign miss_tag = miss_line_q[LINEB-1:IDXB];
  assign unused_pc_lsb = ^PcReq_SY0[1:0];

  assign hit       = valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign fill_ack  = (state_q == ST_REFILL) & MemAck;
  assign fill_last = fill_ack & (word_cnt_q == OFFB'(LINE_WORDS - 1));
  assign fill_mask = LINES'(1) << miss_idx;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!hit) state_d = ST_REFILL;
      ST_REFILL: if (fill_last) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs: lookup result is combinational, memory request decodes the FSM state
  always_comb begin
    InstrFill_SY0 = data_q[{req_idx, req_off}];
    ICacheStall   = 1'b1;
    MemReq        = 1'b0;
    MemAddr       = 32'd0;
    case (state_q)
      ST_IDLE:   ICacheStall = !hit;
      ST_REFILL: begin
        MemReq  = 1'b1;
        MemAddr = {miss_line_q, word_cnt_q, 2'b00};
      end
      default:   ICacheStall = 1'b1;
    endcase
  end

  // Miss line capture and word counter
  always_comb begin
    miss_line_d = miss_line_q;
    word_cnt_d  = word_cnt_q;
    if ((state_q == ST_IDLE) && !hit) begin
      miss_line_d = PcReq_SY0[31:OFFB+2];
      word_cnt_d  = '0;
    end else if (fill_ack) begin
      word_cnt_d  = word_cnt_q + OFFB'(1);
    end
  end

  // Valid bits: the victim line is dropped when its refill starts so a partly
  // overwritten line never looks valid; invalidation spares the line in flight.
  always_comb begin
    valid_d = valid_q;
    if ((state_q == ST_IDLE) && !hit) valid_d[req_idx] = 1'b0;
    if (InvalidateAll) begin
      if (state_q == ST_IDLE) valid_d = '0;
      else                    valid_d = valid_q & fill_mask;
    end
    if (fill_last) valid_d[miss_idx] = 1'b1;
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      word_cnt_q  <= '0;
      miss_line_q <= '0;
    end else begin
      valid_q     <= valid_d;
      word_cnt_q  <= word_cnt_d;
      miss_line_q <= miss_line_d;
    end
  end

  // Data and tag arrays are not reset; valid gates their use
  always_ff @(posedge clk) begin
    if (!reset && fill_ack) begin
      data_q[{miss_idx, word_cnt_q}] <= MemRdata;
      if (fill_last) tag_q[miss_idx] <= miss_tag;
    end
  end

endmodule
